// File: rtl/mux_arb_rr.sv
// +-----------------------------------------------------------------------------+
// | mux_arb_rr                                                                  |
// | Registered NCH-to-1 multiplexer with round-robin arbitration and            |
// | valid/ready handshakes. Optional transfer counter: MUX_ARB_CNT_EN.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mux_arb_rr #(
   parameter int NCH   = 4,
   parameter int WIDTH = 2,
   parameter int CNT_W = 8,
   localparam int SW   = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH*WIDTH-1:0] data_in,
   input  logic [NCH-1:0]       valid_in,
   output logic [NCH-1:0]       ready_out,
   output logic [WIDTH-1:0]     data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
`ifdef MUX_ARB_CNT_EN
   output logic [CNT_W-1:0]     xfer_cnt,
`endif
   output logic [SW-1:0]        sel_out
);

   localparam logic [SW:0] C_NCH = (SW+1)'(NCH);

   logic [SW-1:0]    ptr_q, ptr_d;
   logic [SW-1:0]    sel_q, sel_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   logic [SW-1:0]    w_grant;
   logic             w_found;
   logic [SW:0]      w_idx;
   logic [SW:0]      w_nxt;
   logic [SW-1:0]    w_ptr_next;
   logic [WIDTH-1:0] w_grant_data;
   logic             w_load_en;
   logic             w_any_valid;
   logic             w_xfer;

   assign w_load_en   = !valid_q || ready_in;
   assign w_any_valid = |valid_in;
   assign w_xfer      = w_load_en && w_any_valid;

   // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-two NCH works.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NCH; k++) begin
         w_idx = {1'b0, ptr_q} + (SW+1)'(k);
         if (w_idx >= C_NCH) begin
            w_idx = w_idx - C_NCH;
         end
         if (!w_found && valid_in[w_idx[SW-1:0]]) begin
            w_found = 1'b1;
            w_grant = w_idx[SW-1:0];
         end
      end
   end

   always_comb begin
      w_grant_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant == SW'(i)) begin
            w_grant_data = data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_nxt      = {1'b0, w_grant} + (SW+1)'(1);
   assign w_ptr_next = (w_nxt == C_NCH) ? '0 : w_nxt[SW-1:0];

   always_comb begin
      ready_out = '0;
      if (!reset && w_xfer) begin
         ready_out[w_grant] = 1'b1;
      end
   end

   always_comb begin
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (w_load_en) begin
         if (w_any_valid) begin
            data_d  = w_grant_data;
            sel_d   = w_grant;
            valid_d = 1'b1;
            ptr_d   = w_ptr_next;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

`ifdef MUX_ARB_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of words taken by the consumer.
   always_comb begin
      cnt_d = cnt_q;
      if (valid_q && ready_in && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign xfer_cnt = cnt_q;
`endif

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign sel_out   = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_rr.sv
// +-----------------------------------------------------------------------------+
// | tb_mux_arb_rr                                                               |
// | Self-checking bench for mux_arb_rr against a behavioural reference model.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mux_arb_rr;

   localparam int NCH   = 4;
   localparam int WIDTH = 2;
   localparam int SW    = $clog2(NCH);
`ifdef MUX_ARB_CNT_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 8;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NCH*WIDTH-1:0] data_in;
   logic [NCH-1:0]       valid_in;
   logic [NCH-1:0]       ready_out;
   logic [WIDTH-1:0]     data_out;
   logic                 valid_out;
   logic                 ready_in;
   logic [SW-1:0]        sel_out;
`ifdef MUX_ARB_CNT_EN
   logic [CNT_W-1:0]     xfer_cnt;
`endif

   mux_arb_rr #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
`ifdef MUX_ARB_CNT_EN
      .xfer_cnt  (xfer_cnt),
`endif
      .sel_out   (sel_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_sel;
   int               m_ptr;
   int               m_cnt;
   int               last_grant;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_reset();
      m_valid    = 1'b0;
      m_data     = '0;
      m_sel      = 0;
      m_ptr      = 0;
      m_cnt      = 0;
      last_grant = -1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
      check({tag, ".data"},  32'(data_out),  32'(m_data));
      check({tag, ".sel"},   32'(sel_out),   32'(m_sel));
`ifdef MUX_ARB_CNT_EN
      check({tag, ".cnt"},   32'(xfer_cnt),  32'(m_cnt));
`endif
   endtask

   // One clock: inputs already driven; predict, check ready_out, clock, check outputs.
   task automatic step(input string tag);
      int               g;
      logic             load;
      logic [NCH-1:0]   exp_rdy;
      logic [WIDTH-1:0] word;
      load = !m_valid || ready_in;
      g    = -1;
      for (int k = 0; k < NCH; k++) begin
         if (g < 0 && valid_in[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
      end
      exp_rdy = '0;
      if (load && g >= 0) exp_rdy[g] = 1'b1;
      @(negedge clk);
      check({tag, ".ready"}, 32'(ready_out), 32'(exp_rdy));
      last_grant = (load && g >= 0) ? g : -1;
      @(posedge clk);
      if (m_valid && ready_in && m_cnt < (2**CNT_W - 1)) m_cnt++;
      if (load) begin
         if (g >= 0) begin
            word    = data_in[g*WIDTH +: WIDTH];
            m_data  = word;
            m_sel   = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % NCH;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
      check_outputs(tag);
   endtask

   initial begin
      reset    = 1'b1;
      valid_in = 4'b1111;
      data_in  = 8'b11_10_01_00;
      ready_in = 1'b1;
      model_reset();
      #1;
      check_outputs("rst");
      check("rst.ready", 32'(ready_out), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // All channels requesting: sel/data rotate 0,1,2,3,0
      for (int i = 0; i < 5; i++) step("rot");

      // Sparse requests alternate 1,3
      valid_in = 4'b1010;
      for (int i = 0; i < 4; i++) step("sparse");

      // Backpressure holds everything, then loads with no bubble
      valid_in = 4'b1111;
      ready_in = 1'b0;
      for (int i = 0; i < 3; i++) step("bp");
      ready_in = 1'b1;
      step("bp_rel");

      // Idle: valid_out drops, data/sel keep last values
      valid_in = '0;
      step("idle");
      step("idle2");

      // Async reset between edges
      valid_in = 4'b0110;
      step("pre_rst");
      step("pre_rst2");
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_outputs("arst");
      check("arst.ready", 32'(ready_out), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      valid_in = 4'b1000;
      step("post_rst");

      // Randomized traffic; producers hold valid/data until accepted
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if (!valid_in[c] || last_grant == c) begin
               valid_in[c]                = 1'($urandom % 2);
               data_in[c*WIDTH +: WIDTH]  = WIDTH'($urandom);
            end
         end
         ready_in = ($urandom % 4) != 0;
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
